// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator family.
//   lfsr_topo_e  : feedback topology select (Fibonacci / Galois)
//   LFSR_TAPS_*  : maximal-length tap masks for common widths
//   lfsr_next()  : one-step state update for either topology, up to 32 bits
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB    = 1'b0,
    LFSR_GALOIS = 1'b1
  } lfsr_topo_e;

  localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  // state/taps are right-aligned in 32 bits; width gives the live register
  // size so the Galois MSB and the result mask can be located.
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] state,
    input logic [31:0] taps,
    input lfsr_topo_e  topo,
    input logic [5:0]  width
  );
    logic [31:0] mask;
    logic [31:0] s;
    logic [31:0] nxt;
    logic [4:0]  msb_idx;
    mask    = (width >= 6'd32) ? '1 : ((32'd1 << width) - 32'd1);
    msb_idx = 5'(width - 6'd1);
    s       = state & mask;
    if (topo == LFSR_FIB) begin
      nxt = {s[30:0], ^(s & taps)};
    end else begin
      nxt = {s[30:0], 1'b0} ^ (s[msb_idx] ? {taps[30:0], 1'b1} : '0);
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Period monitor for lfsr_gen.
// Tracks the start value of the current sequence, counts steps from it and
// captures the period whenever the state returns to the start value.
//   clk, reset       : clock, synchronous active-low reset
//   step_i           : an enabled LFSR step happens this cycle
//   restart_i        : a new sequence starts this cycle (load / lock-up recovery)
//   next_i           : state the LFSR register takes at this edge
//   wrap_o           : one-cycle pulse, state returned to start value
//   step_cnt_o       : steps since last start/wrap
//   period_o         : last measured period
//   period_valid_o   : period_o holds a measurement of the current sequence
module lfsr_period_mon
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] next_i,
  output logic             wrap_o,
  output logic [WIDTH-1:0] step_cnt_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o
);

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             wrap_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (restart_i) begin
      // period_q keeps the old measurement; valid_q marks it stale
      start_q <= next_i;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (step_i) begin
      if (next_i == start_q) begin
        wrap_q   <= 1'b1;
        period_q <= cnt_q + WIDTH'(1);
        valid_q  <= 1'b1;
        cnt_q    <= '0;
      end else begin
        wrap_q <= 1'b0;
        cnt_q  <= cnt_q + WIDTH'(1);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap_o         = wrap_q;
  assign step_cnt_o     = cnt_q;
  assign period_o       = period_q;
  assign period_valid_o = valid_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator (Fibonacci or Galois) with step enable,
// runtime seed load, all-zero lock-up protection and a period monitor.
//   clk, reset     : clock, synchronous active-low reset
//   en_i           : advance one step this cycle
//   load_i         : load seed_i this cycle (wins over en_i)
//   seed_i         : runtime seed; zero is replaced by SEED
//   lfsr_o         : current state
//   bit_o          : serial output, lfsr_o[WIDTH-1]
//   lockup_o       : one-cycle pulse, zero state/seed replaced by SEED
//   wrap_o         : one-cycle pulse, state returned to its start value
//   step_cnt_o     : steps since last start/wrap
//   period_o       : last measured period
//   period_valid_o : period_o is valid
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hD008,
  parameter logic [WIDTH-1:0] SEED   = 16'h0001,
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             bit_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] step_cnt_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_gen: SEED must be nonzero");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $fatal(1, "lfsr_gen: TAPS[WIDTH-1] must be set");
  end

  localparam lfsr_topo_e TOPO = GALOIS ? LFSR_GALOIS : LFSR_FIB;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] stepped;
  logic             lockup_q;
  logic             lockup_d;
  logic             step;
  logic             restart;

  assign stepped = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), TOPO, 6'(WIDTH)));

  // Lock-up recovery is treated as a restart so the monitor measures from SEED.
  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    step     = 1'b0;
    restart  = 1'b0;
    if (load_i) begin
      restart = 1'b1;
      if (seed_i == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_i;
      end
    end else if (en_i) begin
      if (state_q == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
        restart  = 1'b1;
      end else begin
        state_d = stepped;
        step    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  lfsr_period_mon #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_mon (
    .clk            (clk),
    .reset          (reset),
    .step_i         (step),
    .restart_i      (restart),
    .next_i         (state_d),
    .wrap_o         (wrap_o),
    .step_cnt_o     (step_cnt_o),
    .period_o       (period_o),
    .period_valid_o (period_valid_o)
  );

  assign lfsr_o   = state_q;
  assign bit_o    = state_q[WIDTH-1];
  assign lockup_o = lockup_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised linear-feedback shift register generator; next generation of the team's 4-bit LFSR.
- Generalised in width, tap polynomial, seed and topology (Fibonacci or Galois).
- Adds step enable, runtime seed load, all-zero lock-up protection and a period monitor.
- Serves as a pseudo-random source for test-pattern generation, scramblers and BIST.

Parameters:
- WIDTH, 16, register width; legal range 3..32.
- TAPS, 16'hD008, feedback tap mask; bit i = 1 means state bit i participates; bit WIDTH-1 must be 1.
- SEED, 16'h0001, start state after reset; must be nonzero (elaboration assertion).
- GALOIS, 0, topology select: 0 = Fibonacci, 1 = Galois.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-low reset.
- en_i, in, 1, advance one step this cycle.
- load_i, in, 1, load seed_i this cycle.
- seed_i, in, WIDTH, runtime seed.
- lfsr_o, out, WIDTH, current state (registered).
- bit_o, out, 1, serial output, equal to lfsr_o[WIDTH-1].
- lockup_o, out, 1, one-cycle pulse: zero seed was replaced by SEED.
- wrap_o, out, 1, one-cycle pulse: state returned to its start value.
- step_cnt_o, out, WIDTH, steps taken since the last start/wrap.
- period_o, out, WIDTH, last measured sequence period.
- period_valid_o, out, 1, period_o holds a valid measurement.

Behaviour:
- Reset: sampled on posedge clk while reset == 0.
  - State and start register are set to SEED.
  - bit_o = SEED[WIDTH-1].
  - lockup_o, wrap_o, step_cnt_o, period_o and period_valid_o are all 0.
- Priority: reset > load_i > en_i. With none active, state and counters hold and pulses return to 0.
- Fibonacci step: next = {s[WIDTH-2:0], ^(s & TAPS)}.
- Galois step: next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : 0).
- Latency:
  - All outputs are registered.
  - An en_i asserted in cycle N is visible on lfsr_o in cycle N+1.
  - en_i held high gives one step per clock.
- Load:
  - Nonzero seed_i: state and start register take seed_i next cycle.
  - seed_i == 0: SEED is substituted and lockup_o pulses for one cycle.
  - In both cases step_cnt_o clears to 0 and period_valid_o clears to 0.
  - A load with en_i also high performs the load only, with no step.
- Lock-up: the all-zero state is unreachable. As defensive logic, if the state is ever 0 and en_i is high, next state = SEED and lockup_o pulses.
- Counters, per enabled step:
  - If the next state equals the start register: wrap_o pulses, period_o = step_cnt_o + 1, period_valid_o = 1, step_cnt_o clears to 0.
  - Otherwise step_cnt_o increments by 1.
  - A maximal-length polynomial gives period 2^WIDTH-1, which always fits in WIDTH bits. step_cnt_o never exceeds 2^WIDTH-2, so the counter never wraps.
- Reset asserted mid-sequence returns every output to its reset value on the next edge; an in-progress measurement is discarded.

Decomposition:
- Shared package lfsr_pkg holds:
  - enum lfsr_topo_e {LFSR_FIB, LFSR_GALOIS}.
  - Standard maximal-tap constants: LFSR_TAPS_4 = 4'b1100, LFSR_TAPS_8 = 8'hB8, LFSR_TAPS_16 = 16'hD008, LFSR_TAPS_32 = 32'h80200003.
  - Pure function lfsr_next(state, taps, topo) implementing both step equations.
- One sub-module, lfsr_period_mon: start register, step counter, period/valid registers and wrap detect. Inputs: step strobe, restart strobe, next state.

Test Plan:
- Fibonacci sequence: WIDTH=4, TAPS=4'b1100, SEED=1, reset released, en_i=1 -> lfsr_o = 1, 2, 4, 9, 3, 6, D on consecutive cycles.
- Galois sequence: same parameters with GALOIS=1, en_i=1 -> lfsr_o = 1, 2, 4, 8, 9, B, F, 7, E.
- Period measurement: WIDTH=4 Fibonacci, en_i held high -> wrap_o pulses 15 cycles after start, period_o = 15, period_valid_o = 1. WIDTH=8, TAPS=8'hB8 -> period_o = 255.
- Zero load and load priority: load_i=1 with seed_i=0 -> lfsr_o = SEED next cycle, lockup_o pulses once, step_cnt_o = 0. load_i=1, seed_i=4'h5, en_i=1 -> lfsr_o = 5 with no step taken.
- Enable gating: en_i toggled 1,0,0,1 -> state advances only on enabled cycles; step_cnt_o increments 1, 1, 1, 2.
- Reset mid-run: reset driven 0 for one cycle after 7 steps -> lfsr_o = SEED; step_cnt_o, period_valid_o, wrap_o and lockup_o are all 0 next cycle. Asynchronous glitches on reset between clock edges -> no effect.
